// File: rtl/imm_pkg.sv
// -----------------------------------------------------------------------------
// imm_pkg
// Shared definitions for the ALU operand-B stage:
//   ext_mode_t - immediate extension mode selected per transaction
//   state_t    - occupancy of the two-entry output skid buffer
//   SHAMT_LSB  - bit position where the shift amount sits inside the immediate
// -----------------------------------------------------------------------------
package imm_pkg;

  typedef enum logic [1:0] {
    EXT_SIGN  = 2'd0,
    EXT_ZERO  = 2'd1,
    EXT_UPPER = 2'd2,
    EXT_SHAMT = 2'd3
  } ext_mode_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam int SHAMT_LSB = 6;

endpackage : imm_pkg

// File: rtl/imm_extend.sv
// -----------------------------------------------------------------------------
// imm_extend
// Purely combinational immediate extender.
// Ports:
//   imm  in  IMM_W  raw immediate
//   mode in  2      extension mode (SIGN, ZERO, UPPER, SHAMT)
//   ext  out XLEN   extended immediate
// Requires XLEN > IMM_W and IMM_W >= SHAMT_LSB + $clog2(XLEN).
// -----------------------------------------------------------------------------
module imm_extend
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int IMM_W = 16
) (
  input  logic [IMM_W-1:0] imm,
  input  ext_mode_t        mode,
  output logic [XLEN-1:0]  ext
);

  localparam int S = $clog2(XLEN);

  // Extension mux; SHAMT keeps only the S bits starting at SHAMT_LSB.
  always_comb begin
    ext = '0;
    case (mode)
      EXT_SIGN:  ext = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
      EXT_ZERO:  ext = {{(XLEN-IMM_W){1'b0}}, imm};
      EXT_UPPER: ext = {imm, {(XLEN-IMM_W){1'b0}}};
      EXT_SHAMT: ext = {{(XLEN-S){1'b0}}, imm[SHAMT_LSB+S-1:SHAMT_LSB]};
      default:   ext = '0;
    endcase
  end

endmodule : imm_extend

// File: rtl/imm_operand_stage.sv
// -----------------------------------------------------------------------------
// imm_operand_stage
// Registered ALU operand-B stage at the ID/EX boundary. Selects rs or an
// extended immediate and holds the result in a 2-entry skid buffer.
// Ports:
//   clk, rst (sync, active-high), flush (sync pipeline flush)
//   in_valid/in_ready     upstream handshake
//   in_imm, in_rs, in_sel_imm, in_mode, in_tag   operand set
//   out_valid/out_ready   downstream handshake
//   out_opb, out_tag      registered operand B and its tag
// -----------------------------------------------------------------------------
module imm_operand_stage
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int IMM_W = 16,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IMM_W-1:0] in_imm,
  input  logic [XLEN-1:0]  in_rs,
  input  logic             in_sel_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_opb,
  output logic [TAG_W-1:0] out_tag
);

  logic [XLEN-1:0]  w_ext;
  logic [XLEN-1:0]  w_operand;
  logic             w_accept;
  logic             w_transfer;
  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_main_ld_in;
  logic             w_main_ld_skid;
  logic             w_skid_ld;
  logic [XLEN-1:0]  r_main_opb;
  logic [TAG_W-1:0] r_main_tag;
  logic [XLEN-1:0]  r_skid_opb;
  logic [TAG_W-1:0] r_skid_tag;

  imm_extend #(
    .XLEN  (XLEN),
    .IMM_W (IMM_W)
  ) u_extend (
    .imm  (in_imm),
    .mode (ext_mode_t'(in_mode)),
    .ext  (w_ext)
  );

  assign w_operand  = in_sel_imm ? w_ext : in_rs;
  // in_ready is masked by rst so nothing is accepted during the reset edge.
  assign in_ready   = (r_state != ST_FULL) & ~rst;
  assign out_valid  = (r_state != ST_EMPTY);
  assign out_opb    = r_main_opb;
  assign out_tag    = r_main_tag;
  assign w_accept   = in_valid & in_ready;
  assign w_transfer = out_valid & out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and data-load decisions; flush discards everything.
  always_comb begin
    w_state_nxt    = r_state;
    w_main_ld_in   = 1'b0;
    w_main_ld_skid = 1'b0;
    w_skid_ld      = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt  = ST_ONE;
            w_main_ld_in = 1'b1;
          end else begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (w_accept && w_transfer) begin
            w_state_nxt  = ST_ONE;
            w_main_ld_in = 1'b1;
          end else if (w_accept) begin
            // Main is still waiting on EX, so the newcomer parks in skid.
            w_state_nxt = ST_FULL;
            w_skid_ld   = 1'b1;
          end else if (w_transfer) begin
            w_state_nxt = ST_EMPTY;
          end else begin
            w_state_nxt = ST_ONE;
          end
        end
        ST_FULL: begin
          if (w_transfer) begin
            w_state_nxt    = ST_ONE;
            w_main_ld_skid = 1'b1;
          end else begin
            w_state_nxt = ST_FULL;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  // Main (output) register; cleared on reset so out_opb/out_tag read zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_opb <= '0;
      r_main_tag <= '0;
    end else if (w_main_ld_in) begin
      r_main_opb <= w_operand;
      r_main_tag <= in_tag;
    end else if (w_main_ld_skid) begin
      r_main_opb <= r_skid_opb;
      r_main_tag <= r_skid_tag;
    end else begin
      r_main_opb <= r_main_opb;
      r_main_tag <= r_main_tag;
    end
  end

  // Skid register holds the second entry while EX stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_skid_opb <= '0;
      r_skid_tag <= '0;
    end else if (w_skid_ld) begin
      r_skid_opb <= w_operand;
      r_skid_tag <= in_tag;
    end else begin
      r_skid_opb <= r_skid_opb;
      r_skid_tag <= r_skid_tag;
    end
  end

endmodule : imm_operand_stage
